// File: rtl/countdown_timer_scheduler_pkg.sv
// rtl/countdown_timer_scheduler_pkg.sv - shared constants for the countdown timer scheduler
// Purpose: FSM state encoding and default parameter values used by the
//          scheduler top level and its arbiter.
package countdown_timer_scheduler_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 4;

  // 2'b11 is unused; the FSM treats it as illegal and returns to IDLE.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COUNT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/countdown_timer_scheduler_rr_arbiter.sv
// rtl/countdown_timer_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request searching upward from last+1,
//          wrapping modulo NUM_REQ, so the previous owner gets lowest priority.
// Ports:
//   req     in   NUM_REQ  request vector
//   last    in   IW       index of the previous owner
//   winner  out  IW       index of the chosen requester
//   onehot  out  NUM_REQ  one-hot form of winner (zero when nothing requested)
//   any     out  1        at least one request is asserted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      winner,
  output logic [NUM_REQ-1:0] onehot,
  output logic               any
);

  // Outer loop walks priority order (offset 1 = highest); the inner loop
  // keeps every bit index a loop constant.
  always_comb begin
    winner = '0;
    onehot = '0;
    any    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
          any       = 1'b1;
          winner    = IW'(i);
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer_scheduler.sv
// rtl/countdown_timer_scheduler.sv - round-robin scheduler sharing one countdown counter
// Purpose: grants a single down counter to one of NUM_REQ requesters, loads
//          that requester's delay, counts to zero and pulses its done.
// Ports:
//   clk    in   1                rising-edge clock
//   reset  in   1                asynchronous active-low reset
//   req    in   NUM_REQ          per-requester level request
//   delay  in   NUM_REQ*WIDTH    packed delays, slice i = delay[i*WIDTH +: WIDTH]
//   abort  in   1                cancel the active countdown (COUNT only)
//   grant  out  NUM_REQ          one-hot owner, zero when idle
//   done   out  NUM_REQ          one-cycle completion pulse
//   busy   out  1                counter owned (COUNT or DONE)
//   count  out  WIDTH            current counter value
module countdown_timer_scheduler
  import countdown_timer_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   delay,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [WIDTH-1:0]           count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         state;
  logic [IW-1:0]      last;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      winner;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_any;
  logic [WIDTH-1:0]   win_delay;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req    (req),
    .last   (last),
    .winner (winner),
    .onehot (win_onehot),
    .any    (win_any)
  );

  // Delay slice of the arbitration winner; only consumed on the grant edge.
  always_comb begin
    win_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) win_delay = delay[i*WIDTH +: WIDTH];
    end
  end

  assign busy = (state == ST_COUNT) || (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      grant <= '0;
      done  <= '0;
      count <= '0;
      owner <= '0;
      last  <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (win_any) begin
            grant <= win_onehot;
            count <= win_delay;
            owner <= winner;
            state <= ST_COUNT;
          end else begin
            grant <= '0;
            count <= '0;
          end
        end
        ST_COUNT: begin
          // abort wins over reaching zero, so an abort on the final count
          // still suppresses done.
          if (abort) begin
            grant <= '0;
            count <= '0;
            last  <= owner;
            state <= ST_IDLE;
          end else if (count == '0) begin
            done  <= grant;
            state <= ST_DONE;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        ST_DONE: begin
          done  <= '0;
          grant <= '0;
          last  <= owner;
          state <= ST_IDLE;
        end
        default: begin
          done  <= '0;
          grant <= '0;
          count <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_scheduler.sv
// tb/tb_countdown_timer_scheduler.sv - scoreboard bench for countdown_timer_scheduler
module tb_countdown_timer_scheduler;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] delay = '0;
  logic           abort = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  countdown_timer_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .delay (delay),
    .abort (abort),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a transaction is (owner, grant edge, delay). done is
  // due D+1 edges after the grant edge, the owner is released one edge later,
  // and the expected count is the delay minus elapsed edges, floored at 0.
  typedef struct {
    int cyc;
    int who;
  } exp_t;

  exp_t exp_q[$];
  int   e       = 0;
  int   m_owner = -1;
  int   m_last  = N - 1;
  int   m_gcyc  = 0;
  int   m_d     = 0;
  int   cand;
  int   since;

  function automatic int model_count();
    int c;
    if (m_owner < 0) return 0;
    c = m_d - (e - m_gcyc);
    return (c < 0) ? 0 : c;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e       = 0;
      m_owner = -1;
      m_last  = N - 1;
      exp_q.delete();
    end else begin
      e++;
      if (m_owner < 0) begin
        if (req != '0) begin
          for (int k = 1; k <= N; k++) begin
            cand = (m_last + k) % N;
            if (m_owner < 0 && req[cand]) m_owner = cand;
          end
          m_gcyc = e;
          m_d    = int'((delay >> (W * m_owner)) & 16'hF);
          exp_q.push_back('{cyc: e + m_d + 1, who: m_owner});
        end
      end else begin
        since = e - m_gcyc;
        if (since == m_d + 2) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (abort) begin
          m_last  = m_owner;
          m_owner = -1;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
      end
    end
  end

  // Monitor: compares outputs each cycle; done is matched against the
  // scoreboard entry due at this edge.
  always @(posedge clk) begin
    int exp_done;
    #1;
    exp_done = 0;
    if (exp_q.size() > 0 && exp_q[0].cyc == e && reset) begin
      exp_done = 1 << exp_q[0].who;
      void'(exp_q.pop_front());
    end
    chk("done",  int'(done),  exp_done);
    chk("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("count", int'(count), model_count());
    chk("busy",  int'(busy),  (m_owner >= 0) ? 1 : 0);
  end

  task automatic wait_owner(input int who, input string name);
    int budget = 60;
    while (m_owner != who && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, m_owner, who);
  endtask

  task automatic wait_idle(input string name);
    int budget = 60;
    while (m_owner >= 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, m_owner, -1);
  endtask

  task automatic wait_count(input int v, input string name);
    int budget = 60;
    while (!(m_owner >= 0 && model_count() == v) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, model_count(), v);
  endtask

  initial begin
    // Reset held with all requests asserted, then round-robin with delay 1.
    reset = 1'b0;
    req   = 4'b1111;
    delay = {4{4'd1}};
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_owner(0, "first_grant_req0");
    repeat (20) @(negedge clk);
    req = '0;
    wait_idle("rr_idle");

    // Single request, delay 3.
    @(negedge clk);
    delay[11:8] = 4'd3;
    req = 4'b0100;
    wait_owner(2, "single_grant");
    wait_idle("single_idle");
    req = '0;
    @(negedge clk);

    // delay 0.
    delay[7:4] = 4'd0;
    req = 4'b0010;
    wait_owner(1, "zero_grant");
    req = '0;
    wait_idle("zero_idle");

    // delay 15, slice changed and req dropped mid-count.
    delay[15:12] = 4'd15;
    req = 4'b1000;
    wait_owner(3, "max_grant");
    delay = 16'($urandom);
    repeat (2) @(negedge clk);
    req = '0;
    wait_idle("max_idle");

    // Abort at count 6, then req 0011 must go to requester 1.
    delay[3:0] = 4'd10;
    req = 4'b0001;
    wait_owner(0, "abort_grant");
    wait_count(6, "abort_at6");
    abort = 1'b1;
    req   = 4'b0011;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_released", m_owner, -1);
    wait_owner(1, "abort_next_owner");
    req = '0;
    wait_idle("abort_idle");

    // Asynchronous reset while count is 5.
    delay[3:0] = 4'd9;
    req = 4'b0001;
    wait_owner(0, "rst_grant");
    wait_count(5, "rst_at5");
    #2 reset = 1'b0;
    #1;
    chk("async_rst_grant", int'(grant), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_busy",  int'(busy),  0);
    chk("async_rst_done",  int'(done),  0);
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    wait_owner(0, "post_rst_req0");
    req = '0;
    wait_idle("post_rst_idle");

    // Randomized traffic.
    repeat (600) begin
      @(negedge clk);
      req   = 4'($urandom_range(0, 15));
      delay = 16'($urandom);
      abort = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    req   = '0;
    abort = 1'b0;
    wait_idle("drain_idle");
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
